clk_enable_divider: RTL and testbench
=====================================

Name: clk_enable_divider

Overview:
Parametrised successor to the ripple toggle-flop clock divider at the top level. It replaces derived clocks with a single-clock design that emits a one-cycle clock-enable `tick` and a registered 50%-duty `clk_out`. The divisor is runtime-programmable and the block supports run, stop and single-step modes. It sits between the oscillator domain and the CPU/memory enables, and lets a debug host single-step the core.

Parameters:
WIDTH, 16, bit width of the divisor and internal counter.
DEFAULT_DIV, 8, divisor loaded at reset (must be >=1 and <2^WIDTH).

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
run  in  1  level; 1 = free-running ticks, 0 = stop (counter frozen).
step_req  in  1  one-cycle pulse; request exactly one tick while stopped.
step_ack  out  1  one-cycle pulse, coincident with the stepped tick.
div_load  in  1  one-cycle pulse; capture div_value as the pending divisor.
div_value  in  WIDTH  requested divisor; 0 is treated as 1.
div_active  out  WIDTH  divisor currently in use.
tick  out  1  registered one-cycle enable, once per div_active advancing cycles.
clk_out  out  1  registered; toggles on every tick (period 2*div_active cycles).
busy  out  1  1 while state is RUN or STEP.

Behaviour:
- Reset values:
  - state = IDLE, count = 0, div_active = DEFAULT_DIV, pending_valid = 0.
  - tick = 0, step_ack = 0, clk_out = 0, busy = 0.
  - Reset has priority over every other input. It aborts a step in flight with no ack.
- States:
  - IDLE: run=1 -> RUN. Otherwise step_req=1 -> STEP. If run and step_req are both 1, go to RUN and drop the step (no ack).
  - RUN: run=0 -> IDLE. step_req is ignored.
  - STEP: stays until wrap. On wrap, go to RUN if run=1, else IDLE.
- Advancing cycle = a clock edge at which the registered state is RUN or STEP.
- Each advancing edge:
  - If count == div_active-1: count <= 0, tick <= 1, clk_out <= ~clk_out (wrap).
  - Otherwise: count <= count+1, tick <= 0.
- Non-advancing edges: tick <= 0, count held. Stop/start resumes mid-period.
- Latency: with count=0, entering RUN at edge k gives the first tick high in the cycle after edge k+div_active. After that, tick repeats every div_active cycles.
- step_ack is asserted in exactly the cycle tick is high for the wrap that ends STEP; otherwise it is 0.
- Divisor update:
  - div_load sets pending <= max(div_value, 1) and pending_valid <= 1.
  - A later div_load before application overwrites pending.
  - Application point 1: at a wrap, div_active <= pending and pending_valid <= 0.
  - Application point 2: at any edge where the registered state is IDLE, div_active <= pending, count <= 0 and pending_valid <= 0.
  - A div_load coinciding with a wrap applies the new value at that same wrap.
  - A divisor is never changed mid-period while advancing, so count < div_active always holds.
- div_active = 1: tick is high on every advancing cycle and clk_out toggles every cycle.
- Maximum divisor 2^WIDTH-1; the counter never overflows.
- busy is a registered decode of state.

Decomposition:
- Package clk_div_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, STEP=2'd2);
  - the constant MIN_DIV=1;
  - the function sat_div(value) that maps 0 to 1.
- One natural sub-module, clk_div_counter: count register, wrap compare, tick/clk_out generation, with an advance input and a div_active input.
- The FSM and divisor shadow logic stay in the top of the block.

Test Plan:
- Reset, then run=1 from edge 0 with DEFAULT_DIV=8 -> first tick in cycle 9. Ticks then repeat every 8 cycles, clk_out period is 16 cycles, and div_active reads 8.
- Running with div 8, div_load with value 3 at count=2 -> the current period still ends on the 8-cycle boundary, after which ticks are spaced 3 apart and div_active reads 3 from the wrap cycle.
- Stopped (run=0), step_req pulse with div 4 -> exactly one tick plus step_ack 4 cycles after STEP is entered, then busy=0 and no further ticks. A second step_req gives exactly one more tick.
- div_load with value 0, then run=1 -> div_active=1, tick high every cycle, clk_out toggles every cycle.
- Running with div 8: deassert run at count=5 for 10 cycles, then reassert -> no ticks while stopped, and the next tick comes 3 advancing cycles after restart (count resumes from 5, not 0).
- In STEP with div 8, assert reset at count=4 -> the cycle after reset all outputs are at reset values, there is no step_ack, and div_active returns to 8 even if a pending load existed.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable divider: state encoding and divisor helpers.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int MIN_DIV = 1;

  // A divisor of zero has no meaning, so it is promoted to the smallest legal value.
  function automatic logic [31:0] sat_div(input logic [31:0] value);
    return (value == 32'd0) ? 32'(MIN_DIV) : value;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Period counter: advances on enabled cycles, wraps at div_active-1, and emits
// the registered tick pulse and the toggling clk_out.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             advance_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] div_active_i,
  output logic             wrap_o,
  output logic             tick_o,
  output logic             clk_out_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  assign wrap_o = advance_i && (count_q == (div_active_i - WIDTH'(MIN_DIV)));

  // clear_i only arrives while idle, so it never competes with a wrap.
  always_comb begin
    count_d   = count_q;
    tick_d    = 1'b0;
    clk_out_d = clk_out_q;
    if (clear_i) begin
      count_d = '0;
    end else if (wrap_o) begin
      count_d   = '0;
      tick_d    = 1'b1;
      clk_out_d = ~clk_out_q;
    end else if (advance_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/clk_enable_divider.sv
// Single-clock programmable divider with run/stop/single-step control and a
// shadowed divisor that only changes at period boundaries or while idle.
module clk_enable_divider
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic [WIDTH-1:0] div_active,
  output logic             tick,
  output logic             clk_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             busy_q;
  logic             step_ack_q;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] load_val;
  logic             advance, wrap, clear;

  assign advance  = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign load_val = WIDTH'(sat_div(32'(div_value)));

  clk_div_counter #(.WIDTH(WIDTH)) u_counter (
    .clk_i        (clk),
    .reset_i      (reset),
    .advance_i    (advance),
    .clear_i      (clear),
    .div_active_i (div_active_q),
    .wrap_o       (wrap),
    .tick_o       (tick),
    .clk_out_o    (clk_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run)           state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_RUN:  if (!run) state_d = ST_IDLE;
      ST_STEP: if (wrap) state_d = run ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A load landing on a wrap is applied immediately; while idle the pending
  // value is applied and the period restarts, keeping a same-cycle load pending.
  always_comb begin
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    div_active_d = div_active_q;
    clear        = 1'b0;
    if (div_load) begin
      pend_d     = load_val;
      pend_vld_d = 1'b1;
    end
    if (wrap) begin
      if (div_load)        div_active_d = load_val;
      else if (pend_vld_q) div_active_d = pend_q;
      pend_vld_d = 1'b0;
    end else if ((state_q == ST_IDLE) && pend_vld_q) begin
      div_active_d = pend_q;
      pend_vld_d   = div_load;
      clear        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      step_ack_q   <= 1'b0;
      div_active_q <= WIDTH'(DEFAULT_DIV);
      pend_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_STEP);
      step_ack_q   <= wrap && (state_q == ST_STEP);
      div_active_q <= div_active_d;
      pend_vld_q   <= pend_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign step_ack   = step_ack_q;
  assign div_active = div_active_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clk_enable_divider.sv
// Directed bench for clk_enable_divider: run timing, divisor reload, single-step,
// divide-by-one, stop/resume and reset-during-step.
module tb_clk_enable_divider;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             step_req;
  logic             step_ack;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic [WIDTH-1:0] div_active;
  logic             tick;
  logic             clk_out;
  logic             busy;

  int n_chk  = 0;
  int n_pass = 0;

  clk_enable_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step_req   (step_req),
    .step_ack   (step_ack),
    .div_load   (div_load),
    .div_value  (div_value),
    .div_active (div_active),
    .tick       (tick),
    .clk_out    (clk_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    step_req  = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    edge1();
    reset     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; run = 1'b0; step_req = 1'b0; div_load = 1'b0; div_value = '0;

    // Reset state
    do_reset();
    chk("rst_tick",   32'(tick),       32'd0);
    chk("rst_ack",    32'(step_ack),   32'd0);
    chk("rst_clkout", 32'(clk_out),    32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_div",    32'(div_active), 32'd8);

    // Free run at div 8; step_req together with run must be dropped
    run = 1'b1; step_req = 1'b1;
    edge1();
    step_req = 1'b0;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_tick0", 32'(tick), 32'd0);
    for (int i = 1; i <= 40; i++) begin
      edge1();
      chk($sformatf("t1_tick_%0d", i),   32'(tick),     32'(i % 8 == 0));
      chk($sformatf("t1_clkout_%0d", i), 32'(clk_out),  32'((i / 8) % 2));
      chk($sformatf("t1_ack_%0d", i),    32'(step_ack), 32'd0);
    end
    chk("t1_div", 32'(div_active), 32'd8);

    // Reload to 3 at count 2; current period still ends on the 8 boundary
    for (int j = 1; j <= 17; j++) begin
      edge1();
      if (j == 3) div_load = 1'b0;
      chk($sformatf("t2_tick_%0d", j), 32'(tick),
          32'(j == 8 || j == 11 || j == 14 || j == 17));
      chk($sformatf("t2_div_%0d", j), 32'(div_active), (j < 8) ? 32'd8 : 32'd3);
      if (j == 2) begin
        div_load  = 1'b1;
        div_value = 16'd3;
      end
    end

    // Stop at count 5, hold 10 cycles, resume: tick after 3 advancing cycles
    do_reset();
    run = 1'b1;
    edge1();
    for (int i = 1; i <= 5; i++) begin
      edge1();
      chk($sformatf("t5_pre_tick_%0d", i), 32'(tick), 32'd0);
      if (i == 4) run = 1'b0;
    end
    chk("t5_busy_stop", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk($sformatf("t5_hold_tick_%0d", i), 32'(tick), 32'd0);
    end
    run = 1'b1;
    for (int r = 0; r <= 3; r++) begin
      edge1();
      chk($sformatf("t5_res_tick_%0d", r), 32'(tick), 32'(r == 3));
    end
    chk("t5_clkout", 32'(clk_out), 32'd1);

    // Single-step with div 4, twice
    do_reset();
    div_load = 1'b1; div_value = 16'd4;
    edge1();
    div_load = 1'b0;
    edge1();
    chk("t3_div", 32'(div_active), 32'd4);
    for (int k = 0; k < 2; k++) begin
      step_req = 1'b1;
      edge1();
      step_req = 1'b0;
      chk($sformatf("t3_busy_enter_%0d", k), 32'(busy), 32'd1);
      for (int s = 1; s <= 4; s++) begin
        edge1();
        chk($sformatf("t3_tick_%0d_%0d", k, s), 32'(tick),     32'(s == 4));
        chk($sformatf("t3_ack_%0d_%0d", k, s),  32'(step_ack), 32'(s == 4));
        chk($sformatf("t3_busy_%0d_%0d", k, s), 32'(busy),     32'(s < 4));
      end
      for (int s = 0; s < 6; s++) begin
        edge1();
        chk($sformatf("t3_quiet_tick_%0d_%0d", k, s), 32'(tick),     32'd0);
        chk($sformatf("t3_quiet_ack_%0d_%0d", k, s),  32'(step_ack), 32'd0);
      end
      chk($sformatf("t3_clkout_%0d", k), 32'(clk_out), 32'(k == 0));
    end

    // Divisor 0 saturates to 1: tick every cycle, clk_out toggles each cycle
    do_reset();
    div_load = 1'b1; div_value = 16'd0;
    edge1();
    div_load = 1'b0; run = 1'b1;
    edge1();
    chk("t4_div", 32'(div_active), 32'd1);
    chk("t4_tick0", 32'(tick), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      edge1();
      chk($sformatf("t4_tick_%0d", i),   32'(tick),    32'd1);
      chk($sformatf("t4_clkout_%0d", i), 32'(clk_out), 32'(i % 2));
    end

    // Reset in the middle of a step with a pending load
    do_reset();
    step_req = 1'b1;
    edge1();
    step_req = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      edge1();
      chk($sformatf("t6_tick_%0d", s), 32'(tick), 32'd0);
      if (s == 2) begin
        div_load = 1'b1; div_value = 16'd5;
      end
      if (s == 3) div_load = 1'b0;
    end
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    chk("t6_tick",   32'(tick),       32'd0);
    chk("t6_ack",    32'(step_ack),   32'd0);
    chk("t6_clkout", 32'(clk_out),    32'd0);
    chk("t6_busy",   32'(busy),       32'd0);
    chk("t6_div",    32'(div_active), 32'd8);
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk($sformatf("t6_post_ack_%0d", i),  32'(step_ack), 32'd0);
      chk($sformatf("t6_post_tick_%0d", i), 32'(tick),     32'd0);
    end
    chk("t6_div_post", 32'(div_active), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
